// File: rtl/dmem_pkg.sv
// Shared types, constants and address helper for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam int unsigned WORD_BYTES      = 4;
  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned WAIT_CNT_W      = $clog2(MAX_WAIT_STATES + 1);

  // Word index of a byte address; the full upper field is kept so range checks cannot wrap.
  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return 30'(addr >> 2);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 data array: per-byte write enable, combinational read, power-up word i = i.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [31:0]           wdata,
  input  logic [WORD_BYTES-1:0] be,
  output logic [31:0]           rdata
);

  // Each entry holds (word ^ index), so an all-zero power-up image reads back as word i = i.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
  logic [31:0] addr_word;

  assign addr_word = 32'(addr);

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8] ^ addr_word[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr] ^ addr_word;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES-cycle delay, then a held response.
// Optional build macro DMEM_MISALIGN_ERR_EN flags addr[1:0] != 0 as an access error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  dmem_state_t           state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;

  logic        accept;
  logic        enter_resp;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic [31:0] arr_rdata;
  logic [31:0] resp_rdata;
  logic        arr_we;

  // A zero-wait accept goes straight to RESP, so the access uses the bus, not the latches.
  always_comb begin
    accept     = (state == IDLE) && req_valid && req_ready;
    enter_resp = (accept && (WAIT_STATES == 0)) ||
                 ((state == WAIT) && (wait_cnt == WAIT_CNT_W'(1)));
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_err = word_idx(acc_addr) >= 30'(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_ERR_EN
    if (acc_addr[1:0] != 2'b00) begin
      acc_err = 1'b1;
    end
`endif
    resp_rdata = (acc_we || acc_err) ? 32'h0 : arr_rdata;
    arr_we     = enter_resp && acc_we && !acc_err && !rst;
  end

`ifndef DMEM_MISALIGN_ERR_EN
  logic unused_lsbs;
  assign unused_lsbs = ^acc_addr[1:0];
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (acc_addr[ADDR_W+1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            wait_cnt  <= WAIT_CNT_W'(WAIT_STATES);
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= resp_rdata;
              rsp_err   <= acc_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          if (enter_resp) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= resp_rdata;
            rsp_err   <= acc_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, reset corner cases, random vs model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned W     = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[$];

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory seen as a plain word array, updated by access rules.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output logic err);
    longint unsigned idx;
    idx = longint'(addr) / 4;
    err = idx >= DEPTH;
`ifdef DMEM_MISALIGN_ERR_EN
    if (addr % 4 != 0) err = 1'b1;
`endif
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        rd = ref_mem[idx];
      end
    end
  endtask

  task automatic scramble();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, ".ready_wait"}, 64'(n < 20), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    scramble();
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check({name, ".hold"}, 64'({rsp_valid, req_ready, rsp_err, rsp_rdata}),
            64'({1'b1, 1'b0, err, rdata}));
      scramble();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'($urandom);
    check({name, ".after_hs"}, 64'({rsp_valid, req_ready}), 64'b01);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] rd, mrd;
    logic        er, merr;
    int          lat;
    model(v.we, v.addr, v.wdata, v.be, mrd, merr);
    do_req(v.name, v.we, v.addr, v.wdata, v.be, v.hold, rd, er, lat);
    check({v.name, ".rdata"}, 64'(rd), 64'(v.exp_rdata));
    check({v.name, ".err"}, 64'(er), 64'(v.exp_err));
    check({v.name, ".lat"}, 64'(lat), 64'(1 + W));
  endtask

  initial begin
    logic [31:0] rd, mrd, addr;
    logic        er, merr, we;
    int          lat, hold, seen;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);

    // Directed vectors; order matters because stores change later loads.
    tbl.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 0, 32'h4, 1'b0, "load_0x10"});
    tbl.push_back('{1'b1, 32'h08, 32'hDEADBEEF, 4'b0011, 0, 32'h0, 1'b0, "store_0x08"});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 4'h0, 0, 32'h0000BEEF, 1'b0, "load_0x08"});
    tbl.push_back('{1'b0, 32'h14, 32'h0, 4'hF, 5, 32'h5, 1'b0, "load_stall"});
    tbl.push_back('{1'b0, 32'h200, 32'h0, 4'hF, 0, 32'h0, 1'b1, "load_oor"});
    tbl.push_back('{1'b1, 32'h200, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1, "store_oor"});
`ifdef DMEM_MISALIGN_ERR_EN
    tbl.push_back('{1'b0, 32'h05, 32'h0, 4'hF, 0, 32'h0, 1'b1, "load_0x05"});
`else
    tbl.push_back('{1'b0, 32'h05, 32'h0, 4'hF, 0, 32'h1, 1'b0, "load_0x05"});
`endif
    tbl.push_back('{1'b1, 32'h20, 32'h12345678, 4'b0000, 0, 32'h0, 1'b0, "store_be0"});
    tbl.push_back('{1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h8, 1'b0, "load_be0"});
    tbl.push_back('{1'b1, 32'h1FC, 32'hAABBCCDD, 4'b1100, 2, 32'h0, 1'b0, "store_top"});
    tbl.push_back('{1'b0, 32'h1FC, 32'h0, 4'hF, 0, 32'hAABB007F, 1'b0, "load_top"});
    tbl.push_back('{1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, 0, 32'h0, 1'b1, "load_high"});
    tbl.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1, "store_wrap"});
    tbl.push_back('{1'b0, 32'h0, 32'h0, 4'hF, 0, 32'h0, 1'b0, "load_0x00"});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'({req_ready, rsp_valid}), 64'b10);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset during WAIT of a store: dropped, nothing written.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0C; req_wdata = 32'hFFFFFFFF;
    req_be = 4'hF; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    scramble();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait.out", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata}), 64'h0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    check("rst_wait.no_rsp", 64'(seen), 64'd0);
    do_req("rst_wait.load", 1'b0, 32'h0C, 32'h0, 4'hF, 0, rd, er, lat);
    check("rst_wait.rdata", 64'({er, rd}), 64'({1'b0, 32'h3}));

    // Reset while a store response is pending: write already committed, response discarded.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h18; req_wdata = 32'hCAFEF00D;
    req_be = 4'hF; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    scramble();
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[6] = 32'hCAFEF00D;
    check("rst_resp.out", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata}), 64'h0);
    do_req("rst_resp.load", 1'b0, 32'h18, 32'h0, 4'hF, 0, rd, er, lat);
    check("rst_resp.rdata", 64'({er, rd}), 64'({1'b0, 32'hCAFEF00D}));

    // Random traffic against the model
    for (int t = 0; t < 150; t++) begin
      we   = 1'($urandom);
      addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(DEPTH, 4000)) * 4
                                         : 32'($urandom_range(0, DEPTH - 1)) * 4;
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      begin
        logic [31:0] wd;
        logic [3:0]  b;
        wd = req_wdata;
        b  = req_be;
        model(we, addr, wd, b, mrd, merr);
        do_req("rand", we, addr, wd, b, hold, rd, er, lat);
      end
      check("rand.resp", 64'({er, rd}), 64'({merr, mrd}));
      check("rand.lat", 64'(lat), 64'(1 + W));
    end

    // Full-array sweep: nothing outside the modelled writes has changed.
    for (int i = 0; i < DEPTH; i++) begin
      do_req("sweep", 1'b0, 32'(i) * 4, 32'h0, 4'hF, 0, rd, er, lat);
      check($sformatf("sweep[%0d]", i), 64'({er, rd}), 64'({1'b0, ref_mem[i]}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
